arb_mux: RTL and testbench
==========================

Name: arb_mux

Overview:
- Registered N:1 multiplexer with per-channel valid/ready handshake and built-in arbitration. Generalises the combinational muxes in width and channel count.
- Adds arbitration between simultaneous requesters, a one-stage output register and backpressure.
- Sits where several sources share one sink, e.g. instruction-fetch and load/store ports sharing a memory port, or multiple writeback sources.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- NCH, 4, number of input channels; any value >= 2, not restricted to a power of two.
- SELW, max(1, clog2(NCH)), width of the grant index; derived, not overridden.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- reset  in  1  Synchronous, active-high reset.
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round robin.
- d  in  NCH*WIDTH  Flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- d_valid  in  NCH  Per-channel request.
- d_ready  out  NCH  Per-channel accept, one-hot or zero.
- y  out  WIDTH  Registered output data.
- y_valid  out  1  Output holds a word.
- y_ready  in  1  Sink accepts y this cycle.
- sel  out  SELW  Channel index of the word currently in y.

Behaviour:
- Reset (synchronous, active-high): y=0, y_valid=0, sel=0, round-robin pointer ptr=0. While reset=1, d_ready=0.
- Stage free: free = !y_valid | y_ready.
- Arbitration (combinational, every cycle):
  - mode=0: g = lowest i with d_valid[i].
  - mode=1: g = first i with d_valid[i], searching ptr, ptr+1, … NCH-1, 0, … ptr-1 (wrap mod NCH).
- d_ready: d_ready[g]=1 only when free & |d_valid & !reset; all other bits 0. d_ready is combinational from d_valid, y_valid, y_ready and mode, with no path from d.
- Transfer: on an edge where free & |d_valid, load y<=d[g], sel<=g, y_valid<=1. In mode=1 also set ptr<=(g+1) mod NCH; in mode=0 ptr is unchanged.
- Drain: free & no d_valid → y_valid<=0. y and sel hold their last values.
- Stall: y_valid & !y_ready → y, sel, y_valid and ptr hold; d_ready=0.
- Latency and throughput:
  - Latency from input accept to y_valid is 1 cycle.
  - Full throughput of 1 word per cycle when y_ready stays high.
- Simultaneous drain and refill: with y_ready=1 and a pending request, the new word replaces the old one on the same edge with no bubble.
- Mode change: takes effect at the next arbitration. ptr is retained across changes, so a return to mode=1 resumes from the stored ptr.
- Non-power-of-two NCH: ptr and g always stay in 0..NCH-1. The wrap from NCH-1 goes to 0.
- Reset mid-operation: any held word is discarded, y_valid=0 on the next edge, ptr=0. Inputs must re-present their requests.
- Inputs are not required to hold d_valid without a grant; the block places no constraint on them.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - A clog2 constant function used for SELW.
- One sub-module, arb_pick (parameter NCH):
  - Inputs: req[NCH], start[SELW], mode.
  - Outputs: grant index g and any-request flag.
  - Purely combinational rotate-and-priority-encode.
- arb_mux owns the output register, ptr and the handshake.

Test Plan:
- Reset: assert reset with d_valid=4'b1111 → d_ready=0000 while reset=1. After the edge, y_valid=0, sel=0, y=0.
- Round robin, all requesting: NCH=4, mode=1, d_valid=1111, y_ready=1, d={0x33,0x22,0x11,0x00} → sel sequence 0,1,2,3,0; y=0x00,0x11,0x22,0x33,0x00; exactly one d_ready bit high per cycle.
- Fixed priority: mode=0, d_valid=1110 for 4 cycles → sel=1 every cycle, d_ready=0010 every cycle.
- Backpressure: y_valid=1 with y=0x22, then y_ready=0 for 3 cycles with all channels requesting → y=0x22 held, d_ready=0000. On release, the next grant follows the stored ptr.
- Wrap, NCH=3: mode=1, only ch2 and ch0 valid, ptr=2 → grant 2, then ptr wraps to 0 and grants 0, then 2 → sel sequence 2,0,2.
- Reset mid-operation: y_valid=1, ptr=3; assert reset for one cycle → y_valid=0 and ptr=0. With d_valid=1111 and mode=1, the first grant after reset is channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and sizing helpers for the arbitrated output mux.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Grant-index width; a 1-bit index is kept even when clog2 would give 0.
   function automatic int sel_w(input int nch);
      return (clog2(nch) < 1) ? 1 : clog2(nch);
   endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Channel-side and sink-side handshake bundle of the arbitrated output mux.
interface arb_mux_if
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
);

   localparam int SELW = sel_w(NCH);

   logic                   mode;
   logic [NCH*WIDTH-1:0]   d;
   logic [NCH-1:0]         d_valid;
   logic [NCH-1:0]         d_ready;
   logic [WIDTH-1:0]       y;
   logic                   y_valid;
   logic                   y_ready;
   logic [SELW-1:0]        sel;

   modport master (
      output mode, d, d_valid, y_ready,
      input  d_ready, y, y_valid, sel
   );

   modport slave (
      input  mode, d, d_valid, y_ready,
      output d_ready, y, y_valid, sel
   );

endinterface

// File: rtl/arb_pick.sv
// Combinational arbiter: rotate the search start to ptr (round robin) or 0
// (fixed priority) and return the first requesting channel.
module arb_pick
   import mux_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]          req,
   input  logic [sel_w(NCH)-1:0]   start,
   input  logic                    mode,
   output logic [sel_w(NCH)-1:0]   g,
   output logic                    any
);

   localparam int SELW = sel_w(NCH);

   always_comb begin
      int base;
      int idx;
      g    = '0;
      any  = 1'b0;
      base = (mode == MODE_RR) ? int'(start) : 0;
      idx  = 0;
      // Wrap by subtraction so non-power-of-two NCH never leaves 0..NCH-1.
      for (int k = 0; k < NCH; k++) begin
         idx = base + k;
         if (idx >= NCH) idx = idx - NCH;
         if (!any && req[idx[SELW-1:0]]) begin
            any = 1'b1;
            g   = idx[SELW-1:0];
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// Registered N:1 mux: arbitrates among requesting channels and holds the
// winning word in a single output stage with valid/ready backpressure.
module arb_mux
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   arb_mux_if.slave    bus
);

   localparam int SELW = sel_w(NCH);

   logic [WIDTH-1:0] ch [NCH];
   logic [WIDTH-1:0] y_p1;
   logic             vld_p1;
   logic [SELW-1:0]  sel_p1;
   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  g;
   logic             any;
   logic             free;

   arb_pick #(.NCH(NCH)) u_pick (
      .req   (bus.d_valid),
      .start (ptr),
      .mode  (bus.mode),
      .g     (g),
      .any   (any)
   );

   always_comb begin
      for (int i = 0; i < NCH; i++) ch[i] = bus.d[i*WIDTH +: WIDTH];
   end

   // The stage can take a word when empty or when the sink drains it now.
   always_comb begin
      free        = !vld_p1 || bus.y_ready;
      bus.d_ready = '0;
      if (free && any && !reset) bus.d_ready = NCH'(1) << g;
   end

   // Output stage p1
   always_ff @(posedge clk) begin
      if (reset) begin
         y_p1   <= '0;
         vld_p1 <= 1'b0;
         sel_p1 <= '0;
         ptr    <= '0;
      end else if (free) begin
         if (any) begin
            y_p1   <= ch[g];
            sel_p1 <= g;
            vld_p1 <= 1'b1;
            if (bus.mode == MODE_RR) ptr <= (g == SELW'(NCH - 1)) ? '0 : g + SELW'(1);
         end else begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.y       = y_p1;
   assign bus.y_valid = vld_p1;
   assign bus.sel     = sel_p1;

endmodule

// File: tb/tb_arb_mux.sv
// Randomized check of arb_mux (NCH=4 and NCH=3) against a queue-free
// behavioural model of the arbitration and output-stage rules.
module tb_arb_mux;
   import mux_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   arb_mux_if #(.WIDTH(8), .NCH(4)) bus4 ();
   arb_mux_if #(.WIDTH(8), .NCH(3)) bus3 ();

   arb_mux #(.WIDTH(8), .NCH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
   arb_mux #(.WIDTH(8), .NCH(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

   int checks   = 0;
   int failures = 0;

   // Model state per instance: 0 -> NCH=4, 1 -> NCH=3
   int m_y[2], m_v[2], m_sel[2], m_ptr[2];
   int n_y[2], n_v[2], n_sel[2], n_ptr[2];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int pick(input int n, input logic md, input int p, input logic [7:0] req);
      int first;
      first = md ? p : 0;
      for (int k = 0; k < n; k++)
         if (req[(first + k) % n]) return (first + k) % n;
      return -1;
   endfunction

   task automatic unit(input int k, input int n, input logic [7:0] dv, input logic [31:0] dd,
                       input logic md, input logic yr, input logic [7:0] drdy);
      int w;
      bit free;
      logic [7:0] exp_rdy;
      free    = (m_v[k] == 0) || yr;
      w       = pick(n, md, m_ptr[k], dv);
      exp_rdy = (!reset && free && w >= 0) ? (8'(1) << w) : 8'(0);
      check_eq(k == 0 ? "d_ready4" : "d_ready3", 32'(drdy), 32'(exp_rdy));
      n_y[k] = m_y[k]; n_v[k] = m_v[k]; n_sel[k] = m_sel[k]; n_ptr[k] = m_ptr[k];
      if (reset) begin
         n_y[k] = 0; n_v[k] = 0; n_sel[k] = 0; n_ptr[k] = 0;
      end else if (free) begin
         if (w >= 0) begin
            n_y[k]   = int'(dd[w*8 +: 8]);
            n_sel[k] = w;
            n_v[k]   = 1;
            if (md) n_ptr[k] = (w + 1) % n;
         end else begin
            n_v[k] = 0;
         end
      end
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic cycle();
      #1;
      unit(0, 4, 8'(bus4.d_valid), 32'(bus4.d), bus4.mode, bus4.y_ready, 8'(bus4.d_ready));
      unit(1, 3, 8'(bus3.d_valid), 32'(bus3.d), bus3.mode, bus3.y_ready, 8'(bus3.d_ready));
      @(posedge clk);
      m_y = n_y; m_v = n_v; m_sel = n_sel; m_ptr = n_ptr;
      #1;
      check_eq("y4",       32'(bus4.y),       32'(m_y[0]));
      check_eq("y_valid4", 32'(bus4.y_valid), 32'(m_v[0]));
      check_eq("sel4",     32'(bus4.sel),     32'(m_sel[0]));
      check_eq("y3",       32'(bus3.y),       32'(m_y[1]));
      check_eq("y_valid3", 32'(bus3.y_valid), 32'(m_v[1]));
      check_eq("sel3",     32'(bus3.sel),     32'(m_sel[1]));
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_y[k] = 0; m_v[k] = 0; m_sel[k] = 0; m_ptr[k] = 0;
      end
      reset = 1'b1;
      bus4.mode = MODE_FIXED; bus4.d = '0; bus4.d_valid = '0; bus4.y_ready = 1'b1;
      bus3.mode = MODE_FIXED; bus3.d = '0; bus3.d_valid = '0; bus3.y_ready = 1'b1;
      @(negedge clk);

      // Reset with every channel requesting
      bus4.d_valid = 4'b1111;
      cycle();
      check_eq("rst_y_valid", 32'(bus4.y_valid), 32'd0);
      check_eq("rst_sel", 32'(bus4.sel), 32'd0);
      check_eq("rst_y", 32'(bus4.y), 32'd0);
      reset = 1'b0;

      // Round robin, all requesting
      bus4.mode = MODE_RR;
      bus4.d = {8'h33, 8'h22, 8'h11, 8'h00};
      for (int k = 0; k < 5; k++) begin
         cycle();
         check_eq("rr_sel", 32'(bus4.sel), 32'(k % 4));
         check_eq("rr_y", 32'(bus4.y), 32'((k % 4) * 8'h11));
      end

      // Fixed priority with channel 0 idle
      bus4.mode = MODE_FIXED;
      bus4.d_valid = 4'b1110;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check_eq("fp_sel", 32'(bus4.sel), 32'd1);
         check_eq("fp_rdy", 32'(bus4.d_ready), 32'b0010);
      end

      // NCH=3 wrap: put ptr at 2, then alternate between ch2 and ch0
      bus3.mode = MODE_RR;
      bus3.d = {8'hC2, 8'hB1, 8'hA0};
      bus3.d_valid = 3'b010;
      cycle();
      check_eq("wrap_pre", 32'(bus3.sel), 32'd1);
      bus3.d_valid = 3'b101;
      cycle(); check_eq("wrap_sel0", 32'(bus3.sel), 32'd2);
      cycle(); check_eq("wrap_sel1", 32'(bus3.sel), 32'd0);
      cycle(); check_eq("wrap_sel2", 32'(bus3.sel), 32'd2);
      bus3.d_valid = '0;

      // Backpressure holding 0x22
      bus4.mode = MODE_RR;
      bus4.d_valid = 4'b0100;
      cycle();
      check_eq("bp_load", 32'(bus4.y), 32'h22);
      bus4.d_valid = 4'b1111;
      bus4.y_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_eq("bp_hold", 32'(bus4.y), 32'h22);
         check_eq("bp_rdy", 32'(bus4.d_ready), 32'd0);
      end
      bus4.y_ready = 1'b1;
      cycle();
      check_eq("bp_release", 32'(bus4.sel), 32'd3);

      // Reset mid-operation with ptr at 3
      bus4.d_valid = 4'b0100;
      cycle();
      reset = 1'b1;
      bus4.d_valid = 4'b1111;
      cycle();
      check_eq("midrst_valid", 32'(bus4.y_valid), 32'd0);
      reset = 1'b0;
      cycle();
      check_eq("midrst_grant", 32'(bus4.sel), 32'd0);

      // Randomized traffic on both instances
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 15) == 0) bus4.mode = 1'($urandom);
         if ($urandom_range(0, 15) == 0) bus3.mode = 1'($urandom);
         bus4.d       = 32'($urandom);
         bus3.d       = 24'($urandom);
         bus4.d_valid = 4'($urandom);
         bus3.d_valid = 3'($urandom);
         bus4.y_ready = ($urandom_range(0, 3) != 0);
         bus3.y_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
